bm_concat_pack_arb: RTL

Two-requester arbiter and sequencer for the LPM concatenation datapath. It grants one variable-length bit field per cycle under round-robin priority and appends each granted field, MSB-first, to a packing accumulator, the same `{first, second}` ordering as a Verilog concatenation. It emits complete 32-bit words through a valid/ready output port. It sits between field producers (24-bit operand sources) and a word-wide sink in the LPM microbenchmark set.

---
 rtl/bm_concat_pack_arb_if.sv | 34 +++
 rtl/bm_concat_pack_arb.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bm_concat_pack_arb_if.sv
// Handshake bundle for bm_concat_pack_arb: two field requesters, a flush strobe
// and the packed-word output port.
interface bm_concat_pack_arb_if #(
  parameter int BITS = 32
);
  localparam int FW = BITS - 8;
  localparam int LW = $clog2(FW + 1);
  localparam int OW = $clog2(BITS + 1);

  logic          req_a;
  logic          req_b;
  logic [FW-1:0] a;
  logic [FW-1:0] b;
  logic [LW-1:0] len_a;
  logic [LW-1:0] len_b;
  logic          rdy_a;
  logic          rdy_b;
  logic          flush;
  logic          out_valid;
  logic [BITS-1:0] out_data;
  logic [OW-1:0] out_bits;
  logic          out_ready;
  logic          busy;

  modport slave (
    input  req_a, req_b, a, b, len_a, len_b, flush, out_ready,
    output rdy_a, rdy_b, out_valid, out_data, out_bits, busy
  );

  modport master (
    output req_a, req_b, a, b, len_a, len_b, flush, out_ready,
    input  rdy_a, rdy_b, out_valid, out_data, out_bits, busy
  );
endinterface

// File: rtl/bm_concat_pack_arb.sv
// Round-robin two-requester arbiter that packs variable-length fields MSB-first
// into an accumulator and emits full (or flushed, zero-padded) words.
module bm_concat_pack_arb #(
  parameter int BITS = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  bm_concat_pack_arb_if.slave     bus
);
  localparam int FW = BITS - 8;
  localparam int AW = BITS + FW;
  localparam int CW = $clog2(AW + 1);
  localparam int LW = $clog2(FW + 1);
  localparam int OW = $clog2(BITS + 1);
  localparam logic [FW:0] FONE = {{FW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    MODE_ACCUM = 2'd0,
    MODE_EMIT  = 2'd1,
    MODE_FLUSH = 2'd2
  } mode_e;

  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   fill_q, fill_d;
  logic            prio_q, prio_d;
  logic            flush_pend_q, flush_pend_d;
  logic            out_valid_q, out_valid_d;
  logic [BITS-1:0] out_data_q, out_data_d;
  logic [OW-1:0]   out_bits_q, out_bits_d;
  logic            busy_q, busy_d;

  mode_e           mode_s;
  logic            gnt_a_s, gnt_b_s, out_hs_s;

  function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] len);
    return (len > LW'(FW)) ? LW'(FW) : len;
  endfunction

  // Masks the field to its effective length and drops it just below the held bits.
  function automatic logic [AW-1:0] place_field(input logic [FW-1:0] data,
                                                input logic [LW-1:0] len,
                                                input logic [CW-1:0] fill);
    logic [LW-1:0] l;
    logic [FW:0]   mask;
    logic [AW-1:0] wide;
    l    = eff_len(len);
    mask = (FONE << l) - FONE;
    wide = {data & mask[FW-1:0], {BITS{1'b0}}};
    wide = wide << (LW'(FW) - l);
    return wide >> fill;
  endfunction

  // Mode decode; a pending flush always implies a non-empty accumulator.
  always_comb begin
    mode_s = MODE_ACCUM;
    if (fill_q >= CW'(BITS)) begin
      mode_s = MODE_EMIT;
    end else if (flush_pend_q) begin
      mode_s = MODE_FLUSH;
    end else begin
      mode_s = MODE_ACCUM;
    end
  end

  assign gnt_a_s  = reset_n & (mode_s == MODE_ACCUM) & bus.req_a & (~prio_q | ~bus.req_b);
  assign gnt_b_s  = reset_n & (mode_s == MODE_ACCUM) & bus.req_b & (prio_q | ~bus.req_a);
  assign out_hs_s = out_valid_q & bus.out_ready;

  // Next-state: append on grant, shift or clear on output handshake.
  always_comb begin
    acc_d  = acc_q;
    fill_d = fill_q;
    prio_d = prio_q;
    case (mode_s)
      MODE_ACCUM: begin
        if (gnt_a_s) begin
          acc_d  = acc_q | place_field(bus.a, bus.len_a, fill_q);
          fill_d = fill_q + CW'(eff_len(bus.len_a));
          prio_d = 1'b1;
        end else if (gnt_b_s) begin
          acc_d  = acc_q | place_field(bus.b, bus.len_b, fill_q);
          fill_d = fill_q + CW'(eff_len(bus.len_b));
          prio_d = 1'b0;
        end else begin
          acc_d  = acc_q;
        end
      end
      MODE_EMIT: begin
        if (out_hs_s) begin
          acc_d  = acc_q << BITS;
          fill_d = fill_q - CW'(BITS);
        end else begin
          acc_d  = acc_q;
        end
      end
      MODE_FLUSH: begin
        if (out_hs_s) begin
          acc_d  = '0;
          fill_d = '0;
        end else begin
          acc_d  = acc_q;
        end
      end
      default: begin
        acc_d  = '0;
        fill_d = '0;
        prio_d = 1'b0;
      end
    endcase

    flush_pend_d = (flush_pend_q | bus.flush) & (fill_d != '0);
    out_valid_d  = (fill_d >= CW'(BITS)) | flush_pend_d;
    busy_d       = (fill_d != '0) | flush_pend_d;
    if (!out_valid_d) begin
      out_data_d = '0;
      out_bits_d = '0;
    end else if (fill_d >= CW'(BITS)) begin
      out_data_d = acc_d[AW-1 -: BITS];
      out_bits_d = OW'(BITS);
    end else begin
      out_data_d = acc_d[AW-1 -: BITS];
      out_bits_d = OW'(fill_d);
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q        <= '0;
      fill_q       <= '0;
      prio_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_bits_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      prio_q       <= prio_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_bits_q   <= out_bits_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.rdy_a     = gnt_a_s;
  assign bus.rdy_b     = gnt_b_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_bits  = out_bits_q;
  assign bus.busy      = busy_q;
endmodule
